encoder_4x2: RTL and testbench

- 4-to-2 binary encoder with registered outputs. It converts a 4-bit request vector into a 2-bit index, with a valid flag and a multi-hot error flag.
- Used as a small index-generation leaf in the datapath. Downstream logic consumes y only when valid is high.
- Supports two modes: priority encoding (highest set bit wins) and strict one-hot encoding (non-one-hot input flagged).

---
 rtl/encoder_pkg.sv | 17 +
 rtl/encoder_4x2_core.sv | 27 ++
 rtl/encoder_4x2.sv | 64 ++++++
 tb/tb_encoder_4x2.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared widths, index constants and the one-hot helper for the 4-to-2 encoder.
package encoder_pkg;

  localparam int unsigned IDX_W = 2;
  localparam int unsigned REQ_W = 4;

  localparam logic [IDX_W-1:0] IDX0 = 2'd0;
  localparam logic [IDX_W-1:0] IDX1 = 2'd1;
  localparam logic [IDX_W-1:0] IDX2 = 2'd2;
  localparam logic [IDX_W-1:0] IDX3 = 2'd3;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic onehot_check(input logic [REQ_W-1:0] w);
    return (w != '0) && ((w & (w - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/encoder_4x2_core.sv
// Combinational 4-to-2 encoder: index, any-request flag and multi-hot flag.
module encoder_4x2_core
  import encoder_pkg::*;
#(
  parameter bit PRIORITY = 1'b1
) (
  input  logic [REQ_W-1:0] w,
  output logic [IDX_W-1:0] y_c,
  output logic             valid_c,
  output logic             err_c
);

  always_comb begin
    y_c     = IDX0;
    valid_c = (w != '0);
    err_c   = valid_c && !onehot_check(w);

    // The priority chain also yields the correct index for any one-hot input.
    if (w[3])      y_c = IDX3;
    else if (w[2]) y_c = IDX2;
    else if (w[1]) y_c = IDX1;
    else           y_c = IDX0;

    if (!PRIORITY && err_c) y_c = IDX0;
  end

endmodule

// File: rtl/encoder_4x2.sv
// 4-to-2 encoder top: optional output registers and a sticky multi-hot flag.
module encoder_4x2
  import encoder_pkg::*;
#(
  parameter bit PRIORITY = 1'b1,
  parameter bit REG_OUT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_W-1:0] w,
  output logic [IDX_W-1:0] y,
  output logic             valid,
  output logic             err,
  output logic             err_sticky
);

  logic [IDX_W-1:0] y_c;
  logic             valid_c;
  logic             err_c;

  encoder_4x2_core #(.PRIORITY(PRIORITY)) u_core (
    .w       (w),
    .y_c     (y_c),
    .valid_c (valid_c),
    .err_c   (err_c)
  );

  if (REG_OUT) begin : g_reg
    logic [IDX_W-1:0] y_q;
    logic             valid_q;
    logic             err_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        y_q     <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        y_q     <= y_c;
        valid_q <= valid_c;
        err_q   <= err_c;
      end
    end

    always_comb begin
      y     = y_q;
      valid = valid_q;
      err   = err_q;
    end
  end else begin : g_comb
    always_comb begin
      y     = y_c;
      valid = valid_c;
      err   = err_c;
    end
  end

  // Accumulates the visible err, so it rises one edge after err does.
  always_ff @(posedge clk) begin
    if (rst) err_sticky <= 1'b0;
    else     err_sticky <= err_sticky | err;
  end

endmodule

// File: tb/tb_encoder_4x2.sv
// Directed bench for encoder_4x2 in priority, strict and combinational configurations.
module tb_encoder_4x2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] w   = 4'b0000;

  logic [1:0] p_y, s_y, c_y;
  logic       p_valid, s_valid, c_valid;
  logic       p_err, s_err, c_err;
  logic       p_st, s_st, c_st;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  encoder_4x2 #(.PRIORITY(1'b1), .REG_OUT(1'b1)) dut_p (
    .clk(clk), .rst(rst), .w(w), .y(p_y), .valid(p_valid), .err(p_err), .err_sticky(p_st));
  encoder_4x2 #(.PRIORITY(1'b0), .REG_OUT(1'b1)) dut_s (
    .clk(clk), .rst(rst), .w(w), .y(s_y), .valid(s_valid), .err(s_err), .err_sticky(s_st));
  encoder_4x2 #(.PRIORITY(1'b1), .REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst(rst), .w(w), .y(c_y), .valid(c_valid), .err(c_err), .err_sticky(c_st));

  function automatic int popcount(input logic [3:0] v);
    int n = 0;
    for (int b = 0; b < 4; b++) if (v[b]) n++;
    return n;
  endfunction

  function automatic logic [1:0] model_y(input logic [3:0] v, input bit pri);
    int hi = 0;
    for (int b = 0; b < 4; b++) if (v[b]) hi = b;
    if (!pri && popcount(v) > 1) return 2'd0;
    return 2'(hi);
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; w = 4'b0000;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; w = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (p_y !== 2'd0)   begin errors++; $display("FAIL reset_y: got %0d want 0", p_y); end
    checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", p_valid); end
    checks++; if (p_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", p_err); end
    checks++; if (p_st !== 1'b0)  begin errors++; $display("FAIL reset_sticky: got %b want 0", p_st); end
    checks++; if (c_st !== 1'b0)  begin errors++; $display("FAIL reset_sticky_comb: got %b want 0", c_st); end
    @(negedge clk); rst = 1'b0; w = 4'b0100;
    @(posedge clk); #1;
    checks++; if (p_y !== 2'd2)   begin errors++; $display("FAIL release_y: got %0d want 2", p_y); end
    checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL release_valid: got %b want 1", p_valid); end
    checks++; if (p_err !== 1'b0) begin errors++; $display("FAIL release_err: got %b want 0", p_err); end
  endtask

  task automatic test_onehot();
    logic [3:0] vec [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0] exp [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); w = vec[k];
      @(posedge clk); #1;
      checks++; if (p_y !== exp[k]) begin errors++; $display("FAIL onehot_y[%0d]: got %0d want %0d", k, p_y, exp[k]); end
      checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL onehot_valid[%0d]: got %b want 1", k, p_valid); end
      checks++; if (p_err !== 1'b0) begin errors++; $display("FAIL onehot_err[%0d]: got %b want 0", k, p_err); end
      checks++; if (p_st !== 1'b0)  begin errors++; $display("FAIL onehot_sticky[%0d]: got %b want 0", k, p_st); end
      checks++; if (s_y !== exp[k]) begin errors++; $display("FAIL onehot_strict_y[%0d]: got %0d want %0d", k, s_y, exp[k]); end
    end
  endtask

  task automatic test_full_sweep();
    logic [3:0] v;
    logic       ev, ee;
    for (int i = 0; i < 32; i++) begin
      v  = 4'(i);
      ev = (v != 4'b0000);
      ee = (popcount(v) > 1);
      @(negedge clk); w = v;
      #1;
      checks++; if (c_y !== model_y(v, 1'b1)) begin errors++; $display("FAIL sweep_comb_y w=%b: got %0d want %0d", v, c_y, model_y(v, 1'b1)); end
      checks++; if (c_err !== ee) begin errors++; $display("FAIL sweep_comb_err w=%b: got %b want %b", v, c_err, ee); end
      @(posedge clk); #1;
      checks++; if (p_y !== model_y(v, 1'b1)) begin errors++; $display("FAIL sweep_y w=%b: got %0d want %0d", v, p_y, model_y(v, 1'b1)); end
      checks++; if (p_valid !== ev) begin errors++; $display("FAIL sweep_valid w=%b: got %b want %b", v, p_valid, ev); end
      checks++; if (p_err !== ee) begin errors++; $display("FAIL sweep_err w=%b: got %b want %b", v, p_err, ee); end
      checks++; if (s_y !== model_y(v, 1'b0)) begin errors++; $display("FAIL sweep_strict_y w=%b: got %0d want %0d", v, s_y, model_y(v, 1'b0)); end
      checks++; if (s_err !== ee) begin errors++; $display("FAIL sweep_strict_err w=%b: got %b want %b", v, s_err, ee); end
    end
  endtask

  task automatic test_strict();
    do_reset();
    w = 4'b0110;
    @(posedge clk); #1;
    checks++; if (s_y !== 2'd0)     begin errors++; $display("FAIL strict_multi_y: got %0d want 0", s_y); end
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL strict_multi_valid: got %b want 1", s_valid); end
    checks++; if (s_err !== 1'b1)   begin errors++; $display("FAIL strict_multi_err: got %b want 1", s_err); end
    checks++; if (s_st !== 1'b0)    begin errors++; $display("FAIL strict_sticky_early: got %b want 0", s_st); end
    @(negedge clk); w = 4'b1000;
    @(posedge clk); #1;
    checks++; if (s_y !== 2'd3)   begin errors++; $display("FAIL strict_onehot_y: got %0d want 3", s_y); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL strict_onehot_err: got %b want 0", s_err); end
    checks++; if (s_st !== 1'b1)  begin errors++; $display("FAIL strict_sticky: got %b want 1", s_st); end
  endtask

  task automatic test_sticky_collision();
    checks++; if (p_st !== 1'b1) begin errors++; $display("FAIL collide_pre_sticky: got %b want 1", p_st); end
    @(negedge clk); rst = 1'b1; w = 4'b0011;
    @(posedge clk); #1;
    checks++; if (p_st !== 1'b0) begin errors++; $display("FAIL collide_sticky: got %b want 0", p_st); end
    checks++; if (p_y !== 2'd0)  begin errors++; $display("FAIL collide_y: got %0d want 0", p_y); end
    checks++; if (p_err !== 1'b0) begin errors++; $display("FAIL collide_err: got %b want 0", p_err); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (p_err !== 1'b1) begin errors++; $display("FAIL post_collide_err: got %b want 1", p_err); end
    checks++; if (p_y !== 2'd1)   begin errors++; $display("FAIL post_collide_y: got %0d want 1", p_y); end
    checks++; if (p_st !== 1'b0)  begin errors++; $display("FAIL post_collide_sticky_early: got %b want 0", p_st); end
    @(posedge clk); #1;
    checks++; if (p_st !== 1'b1)  begin errors++; $display("FAIL post_collide_sticky: got %b want 1", p_st); end
  endtask

  task automatic test_comb();
    do_reset();
    w = 4'b0100;
    #1;
    checks++; if (c_y !== 2'd2)     begin errors++; $display("FAIL comb_y: got %0d want 2", c_y); end
    checks++; if (c_valid !== 1'b1) begin errors++; $display("FAIL comb_valid: got %b want 1", c_valid); end
    checks++; if (c_err !== 1'b0)   begin errors++; $display("FAIL comb_err: got %b want 0", c_err); end
    @(negedge clk); w = 4'b0011;
    #1;
    checks++; if (c_err !== 1'b1) begin errors++; $display("FAIL comb_multi_err: got %b want 1", c_err); end
    checks++; if (c_st !== 1'b0)  begin errors++; $display("FAIL comb_sticky_before_edge: got %b want 0", c_st); end
    @(posedge clk); #1;
    checks++; if (c_st !== 1'b1)  begin errors++; $display("FAIL comb_sticky_after_edge: got %b want 1", c_st); end
    @(negedge clk); w = 4'b0000;
    #1;
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL comb_zero_valid: got %b want 0", c_valid); end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_full_sweep();
    test_strict();
    test_sticky_collision();
    test_comb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
